hazard_stall_controller: RTL

Sequencing controller for the 5-stage MIPS pipeline. It works alongside the forwarding logic and covers the hazards forwarding cannot resolve: load-use, occupancy of the multi-cycle mult/div unit, and taken-branch flushes. It drives the PC and IF/ID write enables and the IF/ID and ID/EX flush (bubble) controls, and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_stall_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
//
// Sequencing controller for a 5-stage MIPS pipeline. It handles the hazards
// that forwarding cannot resolve:
//   - load-use dependencies
//   - occupancy of the multi-cycle mult/div unit
//   - taken-branch flushes
// It also keeps a saturating count of stall cycles for performance measurement.
//
// Ports:
//   clk               pipeline clock, rising edge
//   reset             synchronous, active-low reset
//   ID_EX_MemRead     instruction in EX is a load
//   ID_EX_RegisterRt  load destination register in EX
//   IF_ID_RegisterRs  Rs of the instruction in ID
//   IF_ID_RegisterRt  Rt of the instruction in ID
//   ID_MulDivStart    instruction in ID is mult/multu/div/divu
//   ID_UsesHiLo       instruction in ID is mfhi/mflo/mthi/mtlo
//   EX_BranchTaken    branch/jump resolved taken in EX this cycle
//   PCWrite           PC register load enable
//   IF_ID_Write       IF/ID register load enable
//   IF_ID_Flush       clear IF/ID to a nop
//   ID_EX_Flush       insert a bubble into ID/EX
//   MulDivBusy        mult/div unit is occupied
//   StallCount        saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_stall_controller #(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W          = 4,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ID_EX_MemRead,
    input  logic [4:0]             ID_EX_RegisterRt,
    input  logic [4:0]             IF_ID_RegisterRs,
    input  logic [4:0]             IF_ID_RegisterRt,
    input  logic                   ID_MulDivStart,
    input  logic                   ID_UsesHiLo,
    input  logic                   EX_BranchTaken,
    output logic                   PCWrite,
    output logic                   IF_ID_Write,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Flush,
    output logic                   MulDivBusy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_busy_cnt;
    logic [CNT_W-1:0]       w_busy_cnt_next;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_md_conflict;
    logic w_stall;
    logic w_accept;

    // Register $zero is never a real dependency.
    assign w_load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                        ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                         (ID_EX_RegisterRt == IF_ID_RegisterRt));

    assign w_md_conflict = (r_state == ST_BUSY) && (ID_UsesHiLo || ID_MulDivStart);

    // A taken branch flushes the ID instruction, so there is nothing to stall.
    assign w_stall = (w_load_use || w_md_conflict) && !EX_BranchTaken;

    // Only an instruction that actually leaves ID may start the unit. While
    // BUSY a new mult/div always stalls, so accept never fires in BUSY.
    assign w_accept = ID_MulDivStart && !w_stall && !EX_BranchTaken;

    // Next-state logic. A branch does not cancel an in-flight operation.
    always_comb begin
        w_state_next    = r_state;
        w_busy_cnt_next = r_busy_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    w_state_next    = ST_BUSY;
                    w_busy_cnt_next = CNT_W'(MULDIV_LATENCY);
                end
            end
            ST_BUSY: begin
                if (r_busy_cnt == CNT_W'(1)) begin
                    w_state_next    = ST_RUN;
                    w_busy_cnt_next = '0;
                end else begin
                    w_busy_cnt_next = r_busy_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next    = ST_RUN;
                w_busy_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_busy_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_busy_cnt <= w_busy_cnt_next;
            if (w_stall && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    // Pipeline controls: branch beats stall, stall beats normal flow.
    // While reset is held, the pipeline is frozen and filled with bubbles.
    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        MulDivBusy  = (r_state == ST_BUSY);
        if (!reset) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            MulDivBusy  = 1'b0;
        end else if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (w_stall) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

    assign StallCount = r_stall_cnt;

endmodule
